// File: rtl/ps2_arrow_keys_pkg.sv
// Shared scan-code constants, decoder state type and arrow-key helpers for the
// PS/2 arrow-key receiver.
package ps2_arrow_keys_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_BAT   = 8'hAA;
    localparam logic [7:0] SC_ERR0  = 8'h00;
    localparam logic [7:0] SC_ERRF  = 8'hFF;

    localparam int KEY_U = 3;
    localparam int KEY_D = 2;
    localparam int KEY_R = 1;
    localparam int KEY_L = 0;

    // Frame bit positions: 0 start, 1..8 data, 9 parity, 10 stop.
    localparam logic [3:0] RX_BIT_LAST_DATA = 4'd8;
    localparam logic [3:0] RX_BIT_PAR       = 4'd9;

    typedef enum logic [1:0] {
        DEC_IDLE,
        DEC_EXT,
        DEC_BRK,
        DEC_EXT_BRK
    } dec_state_e;

    function automatic logic [3:0] arrow_mask(input logic [7:0] sc);
        logic [3:0] m;
        m = 4'b0000;
        case (sc)
            SC_UP:    m[KEY_U] = 1'b1;
            SC_DOWN:  m[KEY_D] = 1'b1;
            SC_RIGHT: m[KEY_R] = 1'b1;
            SC_LEFT:  m[KEY_L] = 1'b1;
            default:  m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic is_reset_code(input logic [7:0] sc);
        return (sc == SC_BAT) || (sc == SC_ERR0) || (sc == SC_ERRF);
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: pin synchronisers, ps2_clk glitch filter, 11-bit
// shifter with start/parity/stop checks and a mid-frame timeout.
module ps2_rx_frame
    import ps2_arrow_keys_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 65000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [3:0]    bcnt_q, bcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [7:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          fall;
    logic          dat_s;

    assign dat_s = dat_sync_q[1];

    // The filtered level only flips after FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        if (clk_sync_q[1] == filt_q) begin
            fcnt_d = '0;
        end else if (fcnt_q == FMAX) begin
            fcnt_d = '0;
            filt_d = ~filt_q;
        end else begin
            fcnt_d = fcnt_q + 1'b1;
        end
    end

    assign fall = filt_q & ~filt_d;

    always_comb begin
        bcnt_d  = bcnt_q;
        tcnt_d  = tcnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        code_d  = code_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (fall) begin
            tcnt_d = '0;
            if (bcnt_q == 4'd0) begin
                if (!dat_s) bcnt_d = 4'd1;
                else        err_d  = 1'b1;
            end else if (bcnt_q <= RX_BIT_LAST_DATA) begin
                shift_d = {dat_s, shift_q[7:1]};
                bcnt_d  = bcnt_q + 4'd1;
            end else if (bcnt_q == RX_BIT_PAR) begin
                par_d  = dat_s;
                bcnt_d = bcnt_q + 4'd1;
            end else begin
                bcnt_d = 4'd0;
                if (dat_s && ((^shift_q) ^ par_q)) begin
                    code_d  = shift_q;
                    valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (bcnt_q != 4'd0) begin
            if (tcnt_q == TMAX) begin
                err_d  = 1'b1;
                bcnt_d = 4'd0;
                tcnt_d = '0;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end else begin
            tcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            bcnt_q     <= 4'd0;
            tcnt_q     <= '0;
            code_q     <= 8'h00;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            bcnt_q     <= bcnt_d;
            tcnt_q     <= tcnt_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    // Shift/parity contents are only meaningful once bcnt_q qualifies them.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign code       = code_q;
    assign code_valid = valid_q;
    assign frame_err  = err_q;

endmodule

// File: rtl/ps2_arrow_keys.sv
// PS/2 arrow-key decoder: turns scan-code set 2 make/break sequences into a
// held-key level vector {U,D,R,L}.
module ps2_arrow_keys
    import ps2_arrow_keys_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 65000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] keys,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    logic [7:0] rx_code;
    logic       rx_valid;
    logic       rx_err;
    dec_state_e state_q, state_d;
    logic [3:0] keys_q, keys_d;

    ps2_rx_frame #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .code      (rx_code),
        .code_valid(rx_valid),
        .frame_err (rx_err)
    );

    always_comb begin
        state_d = state_q;
        keys_d  = keys_q;
        if (rx_err) begin
            state_d = DEC_IDLE;
        end else if (rx_valid) begin
            state_d = DEC_IDLE;
            if (is_reset_code(rx_code)) begin
                keys_d = 4'b0000;
            end else begin
                case (state_q)
                    DEC_IDLE: begin
                        if (rx_code == SC_EXT)      state_d = DEC_EXT;
                        else if (rx_code == SC_BRK) state_d = DEC_BRK;
                    end
                    DEC_EXT: begin
                        if (rx_code == SC_BRK) state_d = DEC_EXT_BRK;
                        else                   keys_d  = keys_q | arrow_mask(rx_code);
                    end
                    DEC_EXT_BRK: keys_d = keys_q & ~arrow_mask(rx_code);
                    // Non-extended break: the released key is not an arrow.
                    DEC_BRK: ;
                    default: state_d = DEC_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DEC_IDLE;
            keys_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            keys_q  <= keys_d;
        end
    end

    assign keys       = keys_q;
    assign code       = rx_code;
    assign code_valid = rx_valid;
    assign frame_err  = rx_err;

endmodule

// File: tb/tb_ps2_arrow_keys.sv
// Scoreboard bench for ps2_arrow_keys: a PS/2 device model sends directed frames
// and a monitor checks every code_valid / frame_err pulse and the keys that follow.
module tb_ps2_arrow_keys;

    localparam int TIMEOUT = 2000;
    localparam int HALF    = 20;   // device clock half-period in system clocks

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] keys;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        logic [3:0] kprev;
        logic [3:0] knext;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] mk = 4'b0000;

    ps2_arrow_keys #(
        .FILTER_LEN (8),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keys      (keys),
        .code      (code),
        .code_valid(code_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(4 * HALF);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send(input logic [7:0] b, input logic [3:0] knext);
        exp_t e;
        e.is_err = 1'b0;
        e.code   = b;
        e.kprev  = mk;
        e.knext  = knext;
        sb_q.push_back(e);
        mk = knext;
        drive_bits(mk_frame(b, 1'b0), 11);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.code   = 8'h00;
        e.kprev  = mk;
        e.knext  = mk;
        sb_q.push_back(e);
    endtask

    // Monitor: every output pulse is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (code_valid || frame_err)) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_pulse", {code_valid, frame_err}, 2'b00);
                end else begin
                    e = sb_q.pop_front();
                    chk("pulse_kind", {code_valid, frame_err}, e.is_err ? 2'b01 : 2'b10);
                    if (!e.is_err) chk("code", code, e.code);
                    chk("keys_before", keys, e.kprev);
                    @(negedge clk);
                    chk("keys_after", keys, e.knext);
                    chk("pulse_width", {code_valid, frame_err}, 2'b00);
                end
            end
        end
    end

    initial begin
        wait_cyc(5);
        @(negedge clk);
        chk("rst_keys", keys, 4'b0000);
        chk("rst_code", code, 8'h00);
        chk("rst_pulses", {code_valid, frame_err}, 2'b00);
        rst_n = 1'b1;
        wait_cyc(20);

        // 1: up make / break
        send(8'hE0, 4'b0000);
        send(8'h75, 4'b1000);
        send(8'hE0, 4'b1000);
        send(8'hF0, 4'b1000);
        send(8'h75, 4'b0000);

        // 2: left + right, release left, keypad 8 ignored
        send(8'hE0, 4'b0000);
        send(8'h6B, 4'b0001);
        send(8'hE0, 4'b0001);
        send(8'h74, 4'b0011);
        send(8'hE0, 4'b0011);
        send(8'hF0, 4'b0011);
        send(8'h6B, 4'b0010);
        send(8'h75, 4'b0010);
        send(8'hE0, 4'b0010);
        send(8'hF0, 4'b0010);
        send(8'h74, 4'b0000);

        // 3: bad parity on E0 leaves the decoder idle, so 75 is keypad
        push_err();
        drive_bits(mk_frame(8'hE0, 1'b1), 11);
        send(8'h75, 4'b0000);

        // 4: partial frame then timeout
        push_err();
        drive_bits(mk_frame(8'h72, 1'b0), 6);
        wait_cyc(TIMEOUT + 10);
        send(8'hE0, 4'b0000);
        send(8'h72, 4'b0100);

        // 5: short ps2_clk glitches are filtered, then BAT clears keys
        send(8'hE0, 4'b0100);
        send(8'hF0, 4'b0100);
        send(8'h72, 4'b0000);
        send(8'hE0, 4'b0000);
        send(8'h75, 4'b1000);
        for (int g = 0; g < 5; g++) begin
            ps2_clk = 1'b0;
            wait_cyc(3);
            ps2_clk = 1'b1;
            wait_cyc(30);
        end
        wait_cyc(TIMEOUT + 50);
        chk("glitch_keys", keys, 4'b1000);
        send(8'hAA, 4'b0000);

        // 6: reset in the middle of an E0 frame
        send(8'hE0, 4'b0000);
        send(8'h75, 4'b1000);
        drive_bits(mk_frame(8'hE0, 1'b0), 5);
        rst_n = 1'b0;
        wait_cyc(3);
        @(negedge clk);
        chk("midrst_keys", keys, 4'b0000);
        chk("midrst_code", code, 8'h00);
        chk("midrst_pulses", {code_valid, frame_err}, 2'b00);
        mk = 4'b0000;
        rst_n = 1'b1;
        wait_cyc(20);
        send(8'hE0, 4'b0000);
        send(8'h72, 4'b0100);

        wait_cyc(200);
        chk("scoreboard_drained", sb_q.size(), 0);
        chk("final_keys", keys, 4'b0100);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
